// File: rtl/byte_serializer.sv
// Byte serializer: FIFO-buffered bytes sent as a start pulse plus 8 LSB-first bits.
// Optional frame counter output when SER_FRAME_CNT_EN is defined.
module byte_serializer #(
    parameter int DEPTH        = 4,
    parameter int GUARD_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   frame_start,
    output logic                   ser_bit,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
`ifdef SER_FRAME_CNT_EN
    ,
    output logic [15:0]            frame_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GLAST =
        GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        START,
        SHIFT,
        GUARD
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [GW-1:0] guard_q, guard_d;
    logic          empty, full, push, pop;

    // Extra wrap bit on each pointer separates full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state_q == IDLE) && !empty;
    assign level    = wr_ptr_q - rd_ptr_q;

    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            guard_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            guard_q  <= guard_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        guard_d  = guard_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    shreg_d = mem_q[rd_ptr_q[AW-1:0]];
                    state_d = START;
                end
            end
            START: begin
                bitcnt_d = '0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                shreg_d  = {1'b0, shreg_q[7:1]};
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    guard_d = '0;
                    state_d = (GUARD_CYCLES == 0) ? IDLE : GUARD;
                end
            end
            GUARD: begin
                guard_d = guard_q + 1'b1;
                if (guard_q == GLAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign frame_start = (state_q == START);
    assign ser_bit     = (state_q == SHIFT) && shreg_q[0];
    assign busy        = (state_q != IDLE);

`ifdef SER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // A pop is exactly the IDLE->START transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else if (pop) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: table of single frames plus burst, full and reset cases.
// A negedge receiver model checks every delivered byte against a scoreboard queue.
module tb_byte_serializer;

    localparam int DEPTH = 4;
    localparam int GAP   = 11;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       frame_start;
    logic       ser_bit;
    logic       busy;
    logic [2:0] level;
`ifdef SER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int checks;
    int failures;
    int cyc;

    logic [7:0] exp_q[$];
    int         fs_times[$];

    typedef struct {
        logic [7:0] din;
        logic [7:0] seq;
    } vec_t;

    vec_t vecs[7];

    byte_serializer #(
        .DEPTH(DEPTH),
        .GUARD_CYCLES(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .frame_start(frame_start),
        .ser_bit(ser_bit),
        .busy(busy),
        .level(level)
`ifdef SER_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Receiver model: samples on negedge like the downstream FSM would.
    bit         rx_on;
    int         rx_n;
    logic [7:0] rx_byte;
    bit         have_last;
    int         last_fs;
    int         fs_count;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            rx_on     = 0;
            have_last = 0;
            fs_count  = 0;
        end else begin
            check("level_max", 32'(level <= 3'(DEPTH)), 32'd1);
            check("ready_vs_level", 32'(in_ready), 32'(level != 3'(DEPTH)));
            if (rx_on) begin
                check("fs_in_frame", 32'(frame_start), 32'd0);
                check("busy_in_frame", 32'(busy), 32'd1);
                rx_byte[rx_n] = ser_bit;
                rx_n++;
                if (rx_n == 8) begin
                    rx_on = 0;
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected", 32'(rx_byte), 32'hFFFF_FFFF);
                    end else begin
                        check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
                    end
                end
            end else begin
                check("ser_idle", 32'(ser_bit), 32'd0);
                if (frame_start) begin
                    check("busy_start", 32'(busy), 32'd1);
                    if (have_last) begin
                        check("fs_gap_min", 32'(cyc - last_fs >= GAP), 32'd1);
                    end
                    fs_times.push_back(cyc);
                    last_fs   = cyc;
                    have_last = 1;
                    fs_count++;
`ifdef SER_FRAME_CNT_EN
                    check("frame_cnt", 32'(frame_cnt), 32'(fs_count));
`endif
                    rx_on = 1;
                    rx_n  = 0;
                end
            end
        end
    end

    task automatic push(input logic [7:0] b, output bit ok);
        in_data  = b;
        in_valid = 1'b1;
        ok       = 0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                exp_q.push_back(b);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (!busy && level == 3'd0) done = 1;
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_and_check(input logic [7:0] b, input logic [7:0] seq,
                                  input string tag);
        bit ok;
        int k;
        push(b, ok);
        if (!ok) return;
        k = 0;
        for (int n = 1; n <= 10 && k == 0; n++) begin
            @(negedge clk);
            if (frame_start) k = n;
        end
        check({tag, "_latency"}, 32'(k), 32'd2);
        if (k == 0) return;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check({tag, "_bit"}, 32'(ser_bit), 32'(seq[7-i]));
        end
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit hit;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        // seq lists the bits in transmission order, first bit in seq[7].
        vecs[0] = '{8'hA5, 8'b10100101};
        vecs[1] = '{8'h01, 8'b10000000};
        vecs[2] = '{8'h80, 8'b00000001};
        vecs[3] = '{8'hFF, 8'b11111111};
        vecs[4] = '{8'h00, 8'b00000000};
        vecs[5] = '{8'h96, 8'b01101001};
        vecs[6] = '{8'h0F, 8'b11110000};

        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_ser", 32'(ser_bit), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            send_and_check(vecs[v].din, vecs[v].seq, "vec");
        end

        // Back-to-back burst: frames must be spaced exactly GAP cycles.
        fs_times.delete();
        push(8'h01, ok);
        push(8'h80, ok);
        push(8'hFF, ok);
        push(8'h00, ok);
        wait_idle();
        check("b2b_frames", 32'(fs_times.size()), 32'd4);
        if (fs_times.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                check("b2b_gap", 32'(fs_times[i] - fs_times[i-1]), 32'(GAP));
            end
        end

        // Fill the FIFO, then a push coinciding with a pop is refused.
        push(8'h11, ok);
        push(8'h22, ok);
        push(8'h33, ok);
        push(8'h44, ok);
        push(8'h55, ok);
        in_data  = 8'h66;
        in_valid = 1'b1;
        hit      = 0;
        for (int n = 0; n < 40 && !hit; n++) begin
            @(negedge clk);
            if (!busy && level == 3'd4) hit = 1;
        end
        check("full_pop_seen", 32'(hit), 32'd1);
        check("full_pop_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("level_after_pop", 32'(level), 32'd3);
        check("ready_after_pop", 32'(in_ready), 32'd1);
        if (in_ready) exp_q.push_back(8'h66);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("level_refill", 32'(level), 32'd4);
        wait_idle();

        // Asynchronous reset in the middle of bit 3.
        push(8'hC3, ok);
        push(8'h5A, ok);
        hit = 0;
        for (int n = 0; n < 10 && !hit; n++) begin
            @(negedge clk);
            if (frame_start) hit = 1;
        end
        check("rst_test_fs", 32'(hit), 32'd1);
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_fs", 32'(frame_start), 32'd0);
        check("midrst_ser", 32'(ser_bit), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_level", 32'(level), 32'd0);
        send_and_check(8'h3C, 8'b00111100, "post_rst");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
